rx_ram_rd_ctrl: RTL and testbench

Read-side controller for the turbo-interleaver sample RAM. After the write-side enable generator has filled one PHY block (PB), this block issues sequential RAM reads starting at the PB base offset. It returns the samples as a valid/ready stream with last-beat marking and tolerates downstream backpressure without loss. It sits between the interleaver RAM read port and the turbo decoder input.

---
 rtl/rx_ram_rd_ctrl_pkg.sv | 28 ++
 rtl/rx_ram_rd_ctrl_rd_skid_fifo.sv | 85 ++++++++
 rtl/rx_ram_rd_ctrl.sv | 168 ++++++++++++++++
 tb/tb_rx_ram_rd_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_ram_rd_ctrl_pkg.sv
// Shared definitions for the turbo-interleaver sample RAM read/write controllers:
// FSM encoding, supported PHY block lengths and PB base offsets.
package rx_ram_rd_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READ  = 2'd2,
      ST_DRAIN = 2'd3
   } rd_state_e;

   localparam logic [11:0] PB16_LEN   = 12'h040;
   localparam logic [11:0] PB136_LEN  = 12'h220;
   localparam logic [11:0] PB520_LEN  = 12'h820;
   localparam logic [11:0] EX_LEN     = 12'h00A;

   localparam logic [11:0] PB16_OFS   = 12'h000;
   localparam logic [11:0] PB136_OFS  = 12'h040;
   localparam logic [11:0] PB520_OFS  = 12'h260;

   function automatic logic is_supported_len(input logic [31:0] len);
      return (len == {20'h00000, PB16_LEN})  ||
             (len == {20'h00000, PB136_LEN}) ||
             (len == {20'h00000, PB520_LEN}) ||
             (len == {20'h00000, EX_LEN});
   endfunction

endpackage

// File: rtl/rx_ram_rd_ctrl_rd_skid_fifo.sv
// Two-entry skid FIFO for RAM return data; head word and valid come straight
// from flops so nothing combinational reaches the downstream interface.
module rd_skid_fifo #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          clr,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head_data,
   output logic          head_vld,
   output logic [1:0]    count
);

   logic [DW-1:0] head_q, head_d;
   logic [DW-1:0] tail_q, tail_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          vld_q, vld_d;
   logic          do_pop_s, do_push_s;

   // Next-state for the head/tail pair; a push into a full FIFO only lands if a pop frees a slot.
   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      cnt_d     = cnt_q;
      do_pop_s  = pop && (cnt_q != 2'd0);
      do_push_s = push && ((cnt_q != 2'd2) || do_pop_s);
      if (clr) begin
         cnt_d = 2'd0;
      end else begin
         case ({do_push_s, do_pop_s})
            2'b10: begin
               if (cnt_q == 2'd0) begin
                  head_d = push_data;
               end else begin
                  tail_d = push_data;
               end
               cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
               if (cnt_q == 2'd2) begin
                  head_d = tail_q;
               end else begin
                  head_d = head_q;
               end
               cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  head_d = push_data;
               end else begin
                  head_d = tail_q;
                  tail_d = push_data;
               end
            end
            default: begin
               cnt_d = cnt_q;
            end
         endcase
      end
      vld_d = (cnt_d != 2'd0);
   end

   // Storage and occupancy flops.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         head_q <= {DW{1'b0}};
         tail_q <= {DW{1'b0}};
         cnt_q  <= 2'd0;
         vld_q  <= 1'b0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
      end
   end

   assign head_data = head_q;
   assign head_vld  = vld_q;
   assign count     = cnt_q;

endmodule

// File: rtl/rx_ram_rd_ctrl.sv
// Read-side controller for the interleaver sample RAM: streams one PHY block
// from its base offset out as valid/ready beats with last marking.
module rx_ram_rd_ctrl
   import rx_ram_rd_ctrl_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          start,
   input  logic [AW-1:0] pb_len,
   input  logic [AW-1:0] pb_offset,
   output logic          ram_ren,
   output logic [AW-1:0] ram_raddr,
   input  logic [DW-1:0] ram_rdata,
   output logic [DW-1:0] out_data,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic          len_err
);

   localparam logic [AW-1:0] ONE_AW = {{(AW-1){1'b0}}, 1'b1};

   rd_state_e     state_q, state_d;
   logic [AW-1:0] len_q, len_d, base_q, base_d;
   logic [AW-1:0] rd_cnt_q, rd_cnt_d, ret_cnt_q, ret_cnt_d;
   logic          inflight_q, inflight_d;
   logic          fin_q, fin_d, done_q, done_d;
   logic          len_err_q, len_err_d, busy_q, busy_d;
   logic          ren_s, clr_s, exit_s, pop_s, len_ok_s;
   logic [AW-1:0] last_idx_s;
   logic [2:0]    occ_s;
   logic [1:0]    fifo_cnt_s;
   logic          fifo_vld_s;
   logic [DW-1:0] fifo_data_s;

   assign len_ok_s   = is_supported_len(32'(pb_len));
   assign last_idx_s = len_q - ONE_AW;
   assign pop_s      = fifo_vld_s && out_rdy;

   // FSM state register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start && len_ok_s) state_d = ST_LOAD;
            else                   state_d = ST_IDLE;
         end
         ST_LOAD: state_d = ST_READ;
         ST_READ: begin
            if (ren_s && (rd_cnt_q == last_idx_s)) state_d = ST_DRAIN;
            else                                   state_d = ST_READ;
         end
         ST_DRAIN: begin
            if (exit_s) state_d = ST_IDLE;
            else        state_d = ST_DRAIN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs; issue is throttled so return data plus in-flight reads never exceed two slots.
   always_comb begin
      occ_s  = {1'b0, fifo_cnt_s} + {2'b00, inflight_q};
      clr_s  = (state_q == ST_LOAD);
      if ((state_q == ST_READ) && (rd_cnt_q < len_q) && (occ_s < (3'd2 + {2'b00, pop_s}))) begin
         ren_s = 1'b1;
      end else begin
         ren_s = 1'b0;
      end
      if ((state_q == ST_DRAIN) && pop_s && (ret_cnt_q == last_idx_s) &&
          !inflight_q && (fifo_cnt_s == 2'd1)) begin
         exit_s = 1'b1;
      end else begin
         exit_s = 1'b0;
      end
   end

   // Datapath next-state: frame latch, counters and status pulses.
   always_comb begin
      len_d     = len_q;
      base_d    = base_q;
      rd_cnt_d  = rd_cnt_q;
      ret_cnt_d = ret_cnt_q;
      if ((state_q == ST_IDLE) && start && len_ok_s) begin
         len_d  = pb_len;
         base_d = pb_offset;
      end else begin
         len_d  = len_q;
         base_d = base_q;
      end
      if (clr_s) begin
         rd_cnt_d  = {AW{1'b0}};
         ret_cnt_d = {AW{1'b0}};
      end else begin
         if (ren_s) rd_cnt_d = rd_cnt_q + ONE_AW;
         else       rd_cnt_d = rd_cnt_q;
         if (pop_s) ret_cnt_d = ret_cnt_q + ONE_AW;
         else       ret_cnt_d = ret_cnt_q;
      end
      inflight_d = ren_s;
      // done trails the DRAIN->IDLE transition by one cycle.
      fin_d      = exit_s;
      done_d     = fin_q;
      len_err_d  = (state_q == ST_IDLE) && start && !len_ok_s;
      busy_d     = (state_d != ST_IDLE);
   end

   // Datapath flops.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         len_q      <= {AW{1'b0}};
         base_q     <= {AW{1'b0}};
         rd_cnt_q   <= {AW{1'b0}};
         ret_cnt_q  <= {AW{1'b0}};
         inflight_q <= 1'b0;
         fin_q      <= 1'b0;
         done_q     <= 1'b0;
         len_err_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         len_q      <= len_d;
         base_q     <= base_d;
         rd_cnt_q   <= rd_cnt_d;
         ret_cnt_q  <= ret_cnt_d;
         inflight_q <= inflight_d;
         fin_q      <= fin_d;
         done_q     <= done_d;
         len_err_q  <= len_err_d;
         busy_q     <= busy_d;
      end
   end

   rd_skid_fifo #(.DW(DW)) u_fifo (
      .clk       (clk),
      .n_rst     (n_rst),
      .clr       (clr_s),
      .push      (inflight_q),
      .push_data (ram_rdata),
      .pop       (pop_s),
      .head_data (fifo_data_s),
      .head_vld  (fifo_vld_s),
      .count     (fifo_cnt_s)
   );

   assign ram_ren   = ren_s;
   assign ram_raddr = base_q + rd_cnt_q;
   assign out_data  = fifo_data_s;
   assign out_vld   = fifo_vld_s;
   assign out_last  = fifo_vld_s && (ret_cnt_q == last_idx_s);
   assign busy      = busy_q;
   assign done      = done_q;
   assign len_err   = len_err_q;

endmodule

// File: tb/tb_rx_ram_rd_ctrl.sv
// Scoreboard bench for rx_ram_rd_ctrl: the driver queues expected addresses and
// beats per PB, a negedge monitor compares whatever the DUT presents.
module tb_rx_ram_rd_ctrl;
   import rx_ram_rd_ctrl_pkg::*;

   localparam int DW = 8;
   localparam int AW = 12;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] pb_len = '0;
   logic [AW-1:0] pb_offset = '0;
   logic          ram_ren;
   logic [AW-1:0] ram_raddr;
   logic [DW-1:0] ram_rdata = '0;
   logic [DW-1:0] out_data;
   logic          out_vld;
   logic          out_rdy = 1'b1;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          len_err;

   beat_t         exp_q[$];
   logic [11:0]   addr_q[$];

   int cyc = 0;
   int n_err = 0, n_chk = 0;
   int t0 = 0, t_start = 0;
   int first_ren = -1, first_vld = -1, last_cyc = -1, last_cnt = 0;
   int done_cyc = -1, done_cnt = 0, lerr_cyc = -1, lerr_cnt = 0;
   int frame_beats = 0, busy_low = 0, issued = 0, popped = 0;
   bit rdy_rand = 1'b0;
   bit hold_pend = 1'b0;
   logic [7:0] hold_data = 8'h00;

   rx_ram_rd_ctrl #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .pb_len    (pb_len),
      .pb_offset (pb_offset),
      .ram_ren   (ram_ren),
      .ram_raddr (ram_raddr),
      .ram_rdata (ram_rdata),
      .out_data  (out_data),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] ram_f(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
   endfunction

   // RAM model: one-cycle read latency
   always @(posedge clk) begin
      if (ram_ren) ram_rdata <= ram_f(ram_raddr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pulse_start(input logic [11:0] len, input logic [11:0] ofs, input bit track);
      @(posedge clk); #1;
      start = 1'b1; pb_len = len; pb_offset = ofs;
      t_start = cyc;
      if (track) begin
         t0 = cyc; first_ren = -1; first_vld = -1; last_cyc = -1; last_cnt = 0;
         done_cyc = -1; frame_beats = 0; busy_low = 0;
         for (int k = 0; k < int'(len); k++) begin
            logic [11:0] a;
            beat_t       b;
            a = ofs + 12'(k);
            b.data = ram_f(a);
            b.last = (k == int'(len) - 1);
            addr_q.push_back(a);
            exp_q.push_back(b);
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc);
      int n = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && n < maxc) begin
         @(negedge clk); #1;
         n++;
      end
      chk("done_seen", 32'(done_cnt != d0), 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ren"},   32'(ram_ren),   32'd0);
      chk({tag, "_raddr"}, 32'(ram_raddr), 32'd0);
      chk({tag, "_data"},  32'(out_data),  32'd0);
      chk({tag, "_vld"},   32'(out_vld),   32'd0);
      chk({tag, "_last"},  32'(out_last),  32'd0);
      chk({tag, "_busy"},  32'(busy),      32'd0);
      chk({tag, "_done"},  32'(done),      32'd0);
      chk({tag, "_lerr"},  32'(len_err),   32'd0);
   endtask

   // out_rdy driver: constant 1 or 50% random
   initial begin
      forever begin
         @(posedge clk); #1;
         out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor / scoreboard
   initial begin
      logic pop_now;
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            hold_pend = 1'b0;
         end else begin
            pop_now = out_vld && out_rdy;
            if (hold_pend) begin
               chk("hold_vld",  32'(out_vld),  32'd1);
               chk("hold_data", 32'(out_data), 32'(hold_data));
            end
            hold_pend = out_vld && !out_rdy;
            hold_data = out_data;
            if (ram_ren) begin
               if (first_ren < 0) first_ren = cyc;
               chk("ren_expected", 32'(addr_q.size() != 0), 32'd1);
               if (addr_q.size() != 0) chk("raddr", 32'(ram_raddr), 32'(addr_q.pop_front()));
               chk("ren_occupancy", 32'((issued - popped - int'(pop_now)) < 2), 32'd1);
               issued++;
            end
            if (!out_vld) chk("last_without_vld", 32'(out_last), 32'd0);
            if (out_vld) begin
               if (first_vld < 0) first_vld = cyc;
               chk("vld_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  chk("out_data", 32'(out_data), 32'(exp_q[0].data));
                  chk("out_last", 32'(out_last), 32'(exp_q[0].last));
               end
               if (out_rdy) begin
                  if (exp_q.size() != 0) void'(exp_q.pop_front());
                  if (out_last) begin
                     last_cnt++;
                     last_cyc = cyc;
                  end
                  frame_beats++;
                  popped++;
               end
            end
            if (exp_q.size() != 0 && cyc > t0 && !busy) busy_low++;
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (len_err) begin
               lerr_cnt++;
               lerr_cyc = cyc;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Directed stimulus
   initial begin
      int d0, l0, i0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      n_rst = 1'b1;

      // PB16 at offset 0, continuous ready: exact latencies
      pulse_start(PB16_LEN, PB16_OFS, 1'b1);
      wait_done(200);
      chk("pb16_first_ren", 32'(first_ren), 32'(t0 + 2));
      chk("pb16_first_vld", 32'(first_vld), 32'(t0 + 4));
      chk("pb16_last_cyc",  32'(last_cyc),  32'(t0 + 67));
      chk("pb16_done_cyc",  32'(done_cyc),  32'(t0 + 69));
      chk("pb16_beats",     32'(frame_beats), 32'd64);
      chk("pb16_last_cnt",  32'(last_cnt),  32'd1);
      chk("pb16_busy_low",  32'(busy_low),  32'd0);

      // PB520 at 0x260: addresses 0x260..0xA7F
      pulse_start(PB520_LEN, PB520_OFS, 1'b1);
      wait_done(2300);
      chk("pb520_beats",    32'(frame_beats), 32'd2080);
      chk("pb520_last_cnt", 32'(last_cnt),  32'd1);
      chk("pb520_busy_low", 32'(busy_low),  32'd0);
      chk("pb520_done_cyc", 32'(done_cyc),  32'(t0 + 2085));
      chk("pb520_addr_left", 32'(addr_q.size()), 32'd0);

      // PB136 with 50% random backpressure
      rdy_rand = 1'b1;
      pulse_start(PB136_LEN, PB136_OFS, 1'b1);
      wait_done(3000);
      rdy_rand = 1'b0;
      chk("pb136_beats",     32'(frame_beats), 32'd544);
      chk("pb136_last_cnt",  32'(last_cnt),  32'd1);
      chk("pb136_exp_left",  32'(exp_q.size()), 32'd0);
      chk("pb136_addr_left", 32'(addr_q.size()), 32'd0);
      chk("pb136_busy_low",  32'(busy_low),  32'd0);

      // Unsupported length
      l0 = lerr_cnt; i0 = issued;
      pulse_start(12'h100, 12'h000, 1'b0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         chk("lerr_busy", 32'(busy), 32'd0);
      end
      chk("lerr_count", 32'(lerr_cnt), 32'(l0 + 1));
      chk("lerr_cyc",   32'(lerr_cyc), 32'(t_start + 1));
      chk("lerr_no_ren", 32'(issued), 32'(i0));

      // Start while busy is ignored, then a start right after done
      pulse_start(PB16_LEN, PB16_OFS, 1'b1);
      repeat (10) @(posedge clk);
      l0 = lerr_cnt;
      pulse_start(PB136_LEN, PB520_OFS, 1'b0);
      wait_done(200);
      chk("ign_beats",    32'(frame_beats), 32'd64);
      chk("ign_done_cyc", 32'(done_cyc), 32'(t0 + 69));
      chk("ign_no_lerr",  32'(lerr_cnt), 32'(l0));
      chk("ign_exp_left", 32'(exp_q.size()), 32'd0);
      pulse_start(PB16_LEN, PB136_OFS, 1'b1);
      wait_done(200);
      chk("b2b_first_ren", 32'(first_ren), 32'(t0 + 2));
      chk("b2b_beats",     32'(frame_beats), 32'd64);
      chk("b2b_done_cyc",  32'(done_cyc), 32'(t0 + 69));

      // Reset after 20 beats of PB136
      pulse_start(PB136_LEN, PB136_OFS, 1'b1);
      begin
         int n = 0;
         while (frame_beats < 20 && n < 200) begin
            @(negedge clk); #1;
            n++;
         end
         chk("rst_reached_20", 32'(frame_beats >= 20), 32'd1);
      end
      @(posedge clk); #1;
      n_rst = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      exp_q.delete();
      addr_q.delete();
      issued = 0; popped = 0;
      d0 = done_cnt;
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      chk("midrst_no_done", 32'(done_cnt), 32'(d0));
      chk("midrst_busy",    32'(busy), 32'd0);
      pulse_start(PB16_LEN, PB16_OFS, 1'b1);
      wait_done(200);
      chk("post_rst_first_ren", 32'(first_ren), 32'(t0 + 2));
      chk("post_rst_beats",     32'(frame_beats), 32'd64);
      chk("post_rst_done_cyc",  32'(done_cyc), 32'(t0 + 69));

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
